// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU.
package alu_pkg;

  // Operation codes; values 9..15 are illegal and yield R=0, flags=0.
  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    AND = 4'd2,
    OR  = 4'd3,
    XOR = 4'd4,
    SLT = 4'd5,
    SHL = 4'd6,
    SHR = 4'd7,
    MUL = 4'd8
  } alu_op_t;

  // Bit positions inside the 4-bit flags word.
  localparam int unsigned FLG_N = 3;
  localparam int unsigned FLG_Z = 2;
  localparam int unsigned FLG_C = 1;
  localparam int unsigned FLG_V = 0;

  typedef enum logic {
    IDLE,
    MUL_RUN
  } state_t;

endpackage

// File: rtl/nbit_adder.sv
// Plain ripple N-bit adder with carry in/out; shared by ADD, SUB and SLT.
module nbit_adder #(
  parameter int unsigned N = 8
) (
  input  logic         cin,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         cout,
  output logic [N-1:0] sum
);

  // Zero-extend to N+1 bits so the top bit is the carry out.
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready in and out, NZCV flags and an iterative multiply.
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int unsigned SHW     = $clog2(WIDTH);
  localparam int unsigned CntW    = SHW + 1;
  localparam logic [SHW:0] CntLast = CntW'(WIDTH - 1);

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [SHW:0]         cnt_q, cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [3:0]           flags_q, flags_d;

  logic                 accept, is_mul, mul_done;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;

  logic                 sub_sel, add_cout, add_ovf;
  logic [WIDTH-1:0]     add_b, add_sum;
  logic [SHW-1:0]       shamt;
  logic [2*WIDTH-1:0]   shl_w, shr_w;

  logic [WIDTH-1:0]     alu_r, fin_r;
  logic                 alu_c, alu_v, alu_legal, fin_c, fin_v, fin_legal;

  // Held low during reset so nothing is accepted until the block is live.
  assign in_ready  = rst_n && (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (in_op == MUL);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flags     = flags_q;

  // Subtract is A + ~B + 1: invert B and feed the select in as carry.
  assign sub_sel = (in_op == SUB) || (in_op == SLT);
  assign add_b   = sub_sel ? ~in_b : in_b;

  nbit_adder #(
    .N (WIDTH)
  ) u_adder (
    .cin  (sub_sel),
    .a    (in_a),
    .b    (add_b),
    .cout (add_cout),
    .sum  (add_sum)
  );

  // Overflow on the effective operands covers both ADD and SUB.
  assign add_ovf = (in_a[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != in_a[WIDTH-1]);

  // Double-width shifts keep the last bit shifted out next to the result.
  assign shamt = in_b[SHW-1:0];
  assign shl_w = {{WIDTH{1'b0}}, in_a} << shamt;
  assign shr_w = {in_a, {WIDTH{1'b0}}} >> shamt;

  // One shift-add step: multiplier sits in the low half of acc, consumed LSB first.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  assign mul_done = (state_q == MUL_RUN) && (cnt_q == CntLast);

  // Single-cycle operation decode.
  always_comb begin
    alu_r     = '0;
    alu_c     = 1'b0;
    alu_v     = 1'b0;
    alu_legal = 1'b1;
    case (in_op)
      ADD, SUB: begin
        alu_r = add_sum;
        alu_c = add_cout;
        alu_v = add_ovf;
      end
      SLT: begin
        alu_r = {{(WIDTH-1){1'b0}}, add_sum[WIDTH-1] ^ add_ovf};
        alu_c = add_cout;
        alu_v = add_ovf;
      end
      AND: alu_r = in_a & in_b;
      OR:  alu_r = in_a | in_b;
      XOR: alu_r = in_a ^ in_b;
      SHL: begin
        alu_r = shl_w[WIDTH-1:0];
        alu_c = shl_w[WIDTH];
      end
      SHR: begin
        alu_r = shr_w[2*WIDTH-1:WIDTH];
        alu_c = shr_w[WIDTH-1];
      end
      default: alu_legal = 1'b0;
    endcase
  end

  // Pick the finishing multiply or the single-cycle result, then derive flags.
  always_comb begin
    fin_r     = alu_r;
    fin_c     = alu_c;
    fin_v     = alu_v;
    fin_legal = alu_legal;
    if (mul_done) begin
      fin_r     = mul_next[WIDTH-1:0];
      fin_c     = |mul_next[2*WIDTH-1:WIDTH];
      fin_v     = 1'b0;
      fin_legal = 1'b1;
    end
  end

  // FSM and multiply iterator next state.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept && is_mul) begin
          state_d = MUL_RUN;
          acc_d   = {{WIDTH{1'b0}}, in_b};
          mcand_d = in_a;
          cnt_d   = '0;
        end
      end
      MUL_RUN: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register: a pop clears valid unless a new result lands the same cycle.
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    if (out_ready) out_valid_d = 1'b0;
    if ((accept && !is_mul) || mul_done) begin
      out_valid_d = 1'b1;
      result_d    = fin_r;
      flags_d     = '0;
      if (fin_legal) begin
        flags_d[FLG_N] = fin_r[WIDTH-1];
        flags_d[FLG_Z] = (fin_r == '0);
        flags_d[FLG_C] = fin_c;
        flags_d[FLG_V] = fin_v;
      end
    end
  end

  // State registers; reset discards any in-flight multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH=8) with an expected-result queue.
module tb_seq_alu;

  typedef struct packed {
    logic [7:0] r;
    logic [3:0] f;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
  logic [3:0] flags;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];

  seq_alu #(
    .WIDTH (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent reference written with integer arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int ua, ub, sa, sb, s, amt;
    logic [7:0] r;
    logic c, v;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b); amt = b[2:0];
    r = '0; c = 1'b0; v = 1'b0; s = 0;
    case (op)
      4'd0: begin
        s = ua + ub; r = s[7:0]; c = (s > 255); v = (sa + sb > 127) || (sa + sb < -128);
      end
      4'd1, 4'd5: begin
        s = ua + (255 - ub) + 1; r = s[7:0]; c = (s > 255);
        v = (sa - sb > 127) || (sa - sb < -128);
        if (op == 4'd5) r = (sa < sb) ? 8'd1 : 8'd0;
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd6: begin
        r = 8'(ua << amt); c = (amt != 0) ? ua[8 - amt] : 1'b0;
      end
      4'd7: begin
        r = 8'(ua >> amt); c = (amt != 0) ? ua[amt - 1] : 1'b0;
      end
      4'd8: begin
        s = ua * ub; r = s[7:0]; c = (s > 255);
      end
      default: begin
        e.r = '0; e.f = '0;
        return e;
      end
    endcase
    e.r = r;
    e.f = {r[7], (r == 8'd0), c, v};
    return e;
  endfunction

  // Drive one operation for exactly one accept edge; inputs are scrambled afterwards.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    chk("send_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    sb_q.push_back(model(op, a, b));
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = 4'($urandom); in_a = 8'($urandom); in_b = 8'($urandom);
  endtask

  // Compare the presented output with the queue head and retire it.
  task automatic expect_out(input string tag);
    exp_t e;
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_sb_nonempty"}, {31'd0, (sb_q.size() > 0)}, 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_result"}, {24'd0, result}, {24'd0, e.r});
      chk({tag, "_flags"}, {28'd0, flags}, {28'd0, e.f});
    end
  endtask

  task automatic single(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] b);
    send(op, a, b);
    expect_out(tag);
  endtask

  // Multiply with exact latency and in_ready checks; junk requests are offered meanwhile.
  task automatic run_mul(input string tag, input logic [7:0] a, input logic [7:0] b);
    send(4'd8, a, b);
    chk({tag, "_ready_t0"}, {31'd0, in_ready}, 32'd0);
    for (int i = 1; i <= 7; i++) begin
      in_valid = 1'b1; in_op = 4'd0;
      @(posedge clk); #1;
      chk({tag, "_busy_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_busy_ready"}, {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    expect_out(tag);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
    #12;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_flags", {28'd0, flags}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Spec vectors, issued back to back with the consumer always ready.
    single("add", 4'd0, 8'h7F, 8'h01);
    chk("add_const", {20'd0, result, flags}, {20'd0, 8'h80, 4'b1001});
    single("sub", 4'd1, 8'h05, 8'h05);
    chk("sub_const", {20'd0, result, flags}, {20'd0, 8'h00, 4'b0110});
    single("slt", 4'd5, 8'h80, 8'h01);
    chk("slt_const", {24'd0, result}, 32'h01);
    single("shl", 4'd6, 8'h81, 8'h01);
    chk("shl_const", {20'd0, result, flags}, {20'd0, 8'h02, 4'b0010});
    single("shr0", 4'd7, 8'h81, 8'h00);
    chk("shr0_const", {20'd0, result, flags}, {20'd0, 8'h81, 4'b1000});
    single("and", 4'd2, 8'hF0, 8'h3C);
    single("or", 4'd3, 8'h0F, 8'h30);
    single("xor", 4'd4, 8'h55, 8'hFF);
    single("sub_borrow", 4'd1, 8'h00, 8'h01);
    single("add_carry", 4'd0, 8'hFF, 8'h01);
    single("sub_ovf", 4'd1, 8'h7F, 8'hFF);
    single("slt_neg", 4'd5, 8'h01, 8'hFF);
    single("shr7", 4'd7, 8'hC0, 8'h07);
    single("shl5", 4'd6, 8'h0B, 8'hFD);
    single("illegal", 4'd9, 8'h12, 8'h34);
    @(posedge clk); #1;
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

    run_mul("mul", 8'h10, 8'h10);
    chk("mul_const", {20'd0, result, flags}, {20'd0, 8'h00, 4'b0110});
    run_mul("mul_b", 8'h0D, 8'h0B);
    run_mul("mul_c", 8'hFF, 8'hFF);
    @(posedge clk); #1;

    // Backpressure: output held, held request waits, then pop and accept together.
    out_ready = 1'b0;
    send(4'd0, 8'h12, 8'h34);
    in_valid = 1'b1; in_op = 4'd1; in_a = 8'h09; in_b = 8'h03;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_result", {24'd0, result}, {24'd0, sb_q[0].r});
      chk("bp_flags", {28'd0, flags}, {28'd0, sb_q[0].f});
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    expect_out("bp_add");
    out_ready = 1'b1;
    sb_q.push_back(model(4'd1, 8'h09, 8'h03));
    #1;
    chk("bp_pop_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    expect_out("bp_sub");
    @(posedge clk); #1;
    chk("bp_drain", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a multiply.
    send(4'd8, 8'h03, 8'h05);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_result", {24'd0, result}, 32'd0);
    chk("mrst_flags", {28'd0, flags}, 32'd0);
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd0);
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mrst_ready_after", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("mrst_no_stale", {31'd0, out_valid}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
